// File: rtl/overflow_pkg.sv
// Shared defaults and width helpers for the overflow event logger and its FIFO.
package overflow_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 4;
   localparam int DEF_CNT_WIDTH  = 8;
   localparam int DEF_PTR_W      = $clog2(DEF_DEPTH);

   // Occupancy needs one extra bit so that a full FIFO (DEPTH entries) is representable.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head word is presented combinationally.
module sync_fifo_fwft
   import overflow_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [DATA_WIDTH-1:0]  i_data,
   output logic [DATA_WIDTH-1:0]  o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = level_width(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [LVL_W-1:0]      r_count;

   // NOTE: the storage array is deliberately not reset; r_count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + LVL_W'(i_push) - LVL_W'(i_pop);
      end
   end

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == LVL_W'(DEPTH));
   assign o_level = r_count;
   // Stale storage is masked so the head reads zero whenever nothing is queued.
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/overflow_event_logger.sv
// Captures the data word on each rising edge of the overflow flag, counts events and raises irq.
module overflow_event_logger
   import overflow_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   inValid,
   input  logic [DATA_WIDTH-1:0]  inData,
   input  logic                   inOverflow,
   input  logic                   clear,
   input  logic                   rdReady,
   output logic                   rdValid,
   output logic [DATA_WIDTH-1:0]  rdData,
   output logic [CNT_WIDTH-1:0]   eventCount,
   output logic                   lostEvent,
   output logic                   irq,
   output logic [$clog2(DEPTH):0] level
);

   localparam int LVL_W = level_width(DEPTH);

   logic                 r_prev_ovf;
   logic [CNT_WIDTH-1:0] r_event_count;
   logic                 r_lost;
   logic                 r_irq;

   logic                 w_event;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_drop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_lost_next;
   logic [LVL_W-1:0]     w_level;
   logic [LVL_W-1:0]     w_level_next;

   assign w_event = inValid & inOverflow & ~r_prev_ovf;
   assign w_pop   = ~w_empty & rdReady;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept the new word.
   assign w_push  = w_event & (~w_full | w_pop);
   assign w_drop  = w_event & w_full & ~w_pop;

   assign w_lost_next  = clear ? 1'b0 : (r_lost | w_drop);
   assign w_level_next = w_level + LVL_W'(w_push) - LVL_W'(w_pop);

   sync_fifo_fwft #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (inData),
      .o_data  (rdData),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_ovf    <= 1'b0;
         r_event_count <= '0;
         r_lost        <= 1'b0;
         r_irq         <= 1'b0;
      end else begin
         if (inValid) r_prev_ovf <= inOverflow;
         if (clear) begin
            r_event_count <= '0;
         end else if (w_event && (r_event_count != '1)) begin
            r_event_count <= r_event_count + CNT_WIDTH'(1);
         end
         r_lost <= w_lost_next;
         r_irq  <= (w_level_next != '0) | w_lost_next;
      end
   end

   assign rdValid    = ~w_empty;
   assign level      = w_level;
   assign eventCount = r_event_count;
   assign lostEvent  = r_lost;
   assign irq        = r_irq;

endmodule

// File: tb/tb_overflow_event_logger.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_overflow_event_logger;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 8;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          inValid;
   logic [DW-1:0] inData;
   logic          inOverflow;
   logic          clear;
   logic          rdReady;
   logic          rdValid;
   logic [DW-1:0] rdData;
   logic [CW-1:0] eventCount;
   logic          lostEvent;
   logic          irq;
   logic [2:0]    level;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [DW-1:0] m_q[$];
   logic          m_prev;
   int            m_cnt;
   logic          m_lost;
   logic          m_irq;

   overflow_event_logger #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inValid    (inValid),
      .inData     (inData),
      .inOverflow (inOverflow),
      .clear      (clear),
      .rdReady    (rdReady),
      .rdValid    (rdValid),
      .rdData     (rdData),
      .eventCount (eventCount),
      .lostEvent  (lostEvent),
      .irq        (irq),
      .level      (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_prev = 1'b0;
      m_cnt  = 0;
      m_lost = 1'b0;
      m_irq  = 1'b0;
   endtask

   // Applies one clock edge worth of the behavioural rules to the model.
   task automatic model_step();
      logic ev, drop;
      if (!rst_n) begin
         model_reset();
      end else begin
         ev   = inValid & inOverflow & ~m_prev;
         drop = 1'b0;
         if (m_q.size() != 0 && rdReady) void'(m_q.pop_front());
         if (ev) begin
            if (m_q.size() < DEPTH) m_q.push_back(inData);
            else drop = 1'b1;
         end
         if (inValid) m_prev = inOverflow;
         if (clear) m_cnt = 0;
         else if (ev && m_cnt < CMAX) m_cnt++;
         m_lost = clear ? 1'b0 : (m_lost | drop);
         m_irq  = (m_q.size() != 0) | m_lost;
      end
   endtask

   task automatic compare_all();
      logic [DW-1:0] head;
      head = (m_q.size() != 0) ? m_q[0] : '0;
      check("rdValid",    32'(rdValid),    32'(m_q.size() != 0));
      check("rdData",     32'(rdData),     32'(head));
      check("level",      32'(level),      32'(m_q.size()));
      check("eventCount", 32'(eventCount), 32'(m_cnt));
      check("lostEvent",  32'(lostEvent),  32'(m_lost));
      check("irq",        32'(irq),        32'(m_irq));
   endtask

   // Compare the previous edge's results, drive new inputs, then advance one edge.
   task automatic cycle(input logic v, input logic [DW-1:0] d, input logic o,
                        input logic c, input logic r);
      @(negedge clk);
      compare_all();
      inValid    = v;
      inData     = d;
      inOverflow = o;
      clear      = c;
      rdReady    = r;
      @(posedge clk);
      model_step();
   endtask

   task automatic edge_pulse(input logic [DW-1:0] d, input logic r);
      cycle(1'b1, d, 1'b1, 1'b0, r);
      cycle(1'b1, 8'h00, 1'b0, 1'b0, r);
   endtask

   initial begin
      rst_n = 1'b0;
      inValid = 1'b0; inData = '0; inOverflow = 1'b0; clear = 1'b0; rdReady = 1'b0;
      model_reset();

      // Reset held with random inputs
      for (int i = 0; i < 4; i++)
         cycle(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #2 rst_n = 1'b1;

      // Async reset while three entries are queued
      for (int i = 0; i < 3; i++) edge_pulse(8'(8'h30 + i), 1'b0);
      #1;
      check("pre_reset_level", 32'(level), 32'd3);
      #1 rst_n = 1'b0;
      #1;
      check("async_level",   32'(level),   32'd0);
      check("async_rdValid", 32'(rdValid), 32'd0);
      model_reset();
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;

      // Flag held high for five cycles gives one event
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h12 + i), 1'b1, 1'b0, 1'b0);
      #1;
      check("edge_count", 32'(eventCount), 32'd1);
      check("edge_data",  32'(rdData),     32'h12);
      check("edge_level", 32'(level),      32'd1);
      check("edge_irq",   32'(irq),        32'd1);
      cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

      // Fill and overflow: A4 is dropped
      for (int i = 0; i < 5; i++) edge_pulse(8'(8'hA0 + i), 1'b0);
      #1;
      check("fill_level", 32'(level),      32'd4);
      check("fill_lost",  32'(lostEvent),  32'd1);
      check("fill_count", 32'(eventCount), 32'd5);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
         #1;
         if (i < 3) check("drain_data", 32'(rdData), 32'(8'hA1 + i));
      end
      cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      #1;
      check("drain_level", 32'(level), 32'd0);
      check("irq_sticky",  32'(irq),   32'd1);
      cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      #1;
      check("irq_cleared", 32'(irq), 32'd0);

      // Push and pop together while full
      for (int i = 0; i < 4; i++) edge_pulse(8'(8'hB0 + i), 1'b0);
      cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
      #1;
      check("simul_level", 32'(level),     32'd4);
      check("simul_lost",  32'(lostEvent), 32'd0);
      check("simul_head",  32'(rdData),    32'hB1);
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

      // Counter saturation with continuous draining
      for (int i = 0; i < 260; i++) edge_pulse(8'($urandom), 1'b1);
      #1;
      check("sat_count", 32'(eventCount), 32'hFF);
      cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
      #1;
      check("clear_prio", 32'(eventCount), 32'd0);
      cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);

      // inValid gating: captured flag held while invalid
      cycle(1'b1, 8'h60, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 8'(8'h61 + i), 1'(i), 1'b0, 1'b1);
      cycle(1'b1, 8'h68, 1'b1, 1'b0, 1'b1);
      #1;
      check("gate_count", 32'(eventCount), 32'd1);

      // Random traffic
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
               $urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0);
      @(negedge clk);
      compare_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/overflow_event_logger.md
Name: overflow_event_logger

Overview:
- Sits directly downstream of the overflow indicator stage.
- Consumes its 8-bit data output and overflow flag, and detects rising edges of the flag while input is valid.
- On each edge, captures the accompanying data word into a small FIFO and bumps a saturating event counter.
- The bus controller drains captured words over a valid/ready handshake; an interrupt and a sticky lost-event flag report status.

Parameters:
- DATA_WIDTH, 8, width of captured data word.
- DEPTH, 4, FIFO entries (power of two, >=2).
- CNT_WIDTH, 8, event counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inValid  input  1  inData/inOverflow qualify this cycle
- inData  input  DATA_WIDTH  data word from overflow indicator
- inOverflow  input  1  overflow flag from overflow indicator
- clear  input  1  sync clear of eventCount and lostEvent (FIFO untouched)
- rdReady  input  1  consumer accepts rdData
- rdValid  output  1  FIFO non-empty
- rdData  output  DATA_WIDTH  FIFO head word
- eventCount  output  CNT_WIDTH  saturating count of detected events
- lostEvent  output  1  sticky: an event was dropped because FIFO full
- irq  output  1  registered; high when FIFO non-empty or lostEvent set
- level  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FIFO pointers 0; prevOverflow register 0. Takes effect immediately, mid-operation included. Stored FIFO contents are discarded.
- prevOverflow: updates to inOverflow only on cycles with inValid=1; holds otherwise.
- event: inValid & inOverflow & ~prevOverflow, combinational, evaluated at edge.
  - Continuous high flag yields one event only.
  - A flag that drops and re-rises yields a new event.
- push: event & (not full | pop). Word stored is inData of the event cycle.
- pop: rdValid & rdReady.
- Push and pop in the same cycle:
  - when full: both succeed, level unchanged.
  - when empty: no pop occurs (rdValid=0), push succeeds.
- Dropped event (event & full & ~pop): word discarded, lostEvent<=1 next cycle, eventCount still increments.
- rdData = head entry (FIFO read is first-word-fall-through); rdValid = (level!=0). Both update the cycle after a push into an empty FIFO, so data latency is 1 clock.
- rdData must hold stable while rdValid=1 and rdReady=0.
- eventCount:
  - +1 per event.
  - Saturates at 2^CNT_WIDTH-1; never wraps.
- clear:
  - eventCount<=0 and lostEvent<=0 next cycle.
  - clear has priority over a same-cycle increment/set: the result is 0.
  - FIFO and irq-from-FIFO are unaffected.
- irq: registered, = (next level!=0) | next lostEvent; asserts the cycle after the causing push.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH. level is computed from the counter, not from the pointer difference.
- Data path: no arithmetic on data; width fixed by DATA_WIDTH.

Decomposition:
- Shared package:
  - overflow_pkg: DATA_WIDTH/DEPTH defaults.
  - Localparam for pointer width.
- Natural sub-module: sync_fifo_fwft (parameterised DATA_WIDTH, DEPTH), with push/pop/full/empty/level.
- The logger top holds the edge detect, counter, sticky flag and irq.

Test Plan:
1. Reset: rst_n low with random inputs -> all outputs 0. Assert rst_n=0 while level=3 -> level and rdValid 0 asynchronously, before the next edge.
2. Edge detect: inValid=1; inOverflow high for 5 cycles with inData=8'h12,13,14,15,16 -> one entry 8'h12, eventCount=1, irq=1 one cycle later.
3. Fill/overflow:
   - Five separate rising edges carrying 8'hA0..A4, rdReady=0 -> level=4, FIFO holds A0..A3, A4 dropped.
   - lostEvent=1, eventCount=5.
   - Then rdReady=1 -> rdData A0,A1,A2,A3 on consecutive cycles, level 0; irq stays 1 until clear.
4. Simultaneous: FIFO full, event 8'h55 with rdReady=1 same cycle -> head popped, 8'h55 stored, level stays 4, lostEvent stays 0.
5. Saturation: 260 events with continuous draining -> eventCount stops at 8'hFF. clear with a concurrent event -> eventCount=0 next cycle.
6. inValid gating: inOverflow toggles while inValid=0 -> no events, prevOverflow held. Then inValid=1 with inOverflow=1 after prevOverflow captured 1 -> no event.
